mem_access: RTL and testbench
=============================

# mem_access

Memory-access pipeline stage, directly downstream of execute. Consumes the EX/MEM pipeline register, performs byte/half/word loads and stores over a req/ack data-memory port, and stalls the front of the pipe while a wait-stated access is outstanding. It supplies the MEM-stage forwarding value/tag back to execute, and registers the result into the MEM/WB register.

## Interface
- ACK_TIMEOUT, 255: WAIT cycles without `dmem_ack` before the access is aborted (1..255).
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- ctrl  in  [0:8]  EX/MEM control: [2] mem_read, [3] mem_write, [4] reg_write; other bits pass through
- alu_ctrl  in  [0:5]  EX/MEM ALU function; 6'h0e/6'h16 = signed/unsigned multiply
- alu_out  in  [0:31]  ALU result / effective address
- mult_out  in  [0:31]  low product word
- write_data  in  [0:31]  store data (already forwarded)
- dmem_info  in  [0:2]  [0:1] size (00 byte, 01 half, 10 word), [2] zero-extend load
- write_reg  in  [0:4]  destination register
- dmem_addr  out  [0:31]  word-aligned address (bits [30:31] = 0)
- dmem_wdata  out  [0:31]  lane-replicated store data
- dmem_be  out  [0:3]  byte enables, bit 0 = bits [0:7]
- dmem_req / dmem_we  out  1  request / write strobe
- dmem_rdata  in  [0:31]  read word; dmem_ack  in  1  access complete
- reg_lock  out  1  stall to IF/ID/EX
- write_reg_mem / write_val_mem / reg_write_mem  out  5/32/1  forwarding tag, value, valid
- ctrl_wb  out  [0:9]  registered ctrl; write_reg_wb  out  [0:4]; write_val_wb  out  [0:31]
- bus_err  out  1  one-cycle pulse on timeout; misalign  out  1  one-cycle pulse on misaligned access

## Operation
- mem_op = ctrl[2] | ctrl[3]. Non-memory result = mult_out when alu_ctrl ∈ {0e,16}, else alu_out.
- Big-endian lanes, off = alu_out[30:31]. Byte: be = 4'b1000 >> off, wdata = byte ×4. Half: be = off[0] ? 0011 : 1100, wdata = half ×2. Word: be = 1111.
- Load extract: selected byte/half from rdata, sign-extended unless dmem_info[2].
- FSM IDLE/WAIT. IDLE with mem_op: req=1 combinationally. Ack same cycle → complete, stay IDLE. No ack → WAIT. WAIT: req/addr/be/wdata held, counter increments; ack → IDLE, complete. Counter reaches ACK_TIMEOUT → abort, bus_err pulse, load value 0, IDLE.
- reg_lock = mem_op & ~complete & ~abort (IDLE or WAIT).
- write_val_mem = load value (when ctrl[2]) else result; reg_write_mem = ctrl[4] & ~reg_lock.
- MEM/WB update every cycle: reg_lock=1 loads a bubble (ctrl_wb = 0); otherwise ctrl_wb = ctrl, write_reg_wb, write_val_wb = write_val_mem. Aborted or misaligned loads clear reg_write.

## Timing
- Reset: FSM IDLE, counter 0, ctrl_wb/write_reg_wb/write_val_wb = 0, bus_err = misalign = 0; dmem_req/dmem_we = 0 while rst.
- Zero-wait access: 1 cycle, no stall. N-wait access: reg_lock high N cycles; result in MEM/WB the edge after the ack cycle.
- Inputs must remain stable while reg_lock=1 (execute holds its register).
- Ack in IDLE with no req: ignored. Ack and timeout in the same cycle: ack wins, no bus_err.
- rst mid-WAIT: access dropped immediately, no completion.

## Configuration
- DMEM_ALIGN_CHECK_EN defined: half with off[1]=1 or word with off≠0 issues no request, pulses misalign, suppresses store and reg write, no stall.
- Undefined: misalign tied 0; low address bits ignored (half uses off[0], word uses no offset).

## Test plan
- Reset mid-WAIT of a load → req drops same cycle, ctrl_wb = 0, FSM IDLE, no write on next ack.
- Zero-wait byte store sb to 0x1003, data 0x000000A5 → be = 0001, wdata = 0xA5A5A5A5, reg_lock never high.
- lh from 0x2002, rdata 0x1234F00D, 3 wait states → reg_lock high 3 cycles, write_val_wb = 0xFFFFF00D; with dmem_info[2]=1 → 0x0000F00D.
- Multiply alu_ctrl 0x0e, mult_out 0x00000006 → write_val_mem = 6 same cycle, reg_write_mem = 1.
- Load with no ack, ACK_TIMEOUT=4 → bus_err pulse after 4 WAIT cycles, reg_lock releases, reg_write cleared.
- DMEM_ALIGN_CHECK_EN: lw at 0x3001 → misalign pulse, dmem_req = 0, no reg write; undefined → lw reads word 0x3000.

Source files
------------

// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage with req/ack data port, stall and MEM/WB register.
// Optional DMEM_ALIGN_CHECK_EN: reject misaligned half/word accesses.
module mem_access #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [0:8]  ctrl,
    input  logic [0:5]  alu_ctrl,
    input  logic [0:31] alu_out,
    input  logic [0:31] mult_out,
    input  logic [0:31] write_data,
    input  logic [0:2]  dmem_info,
    input  logic [0:4]  write_reg,
    output logic [0:31] dmem_addr,
    output logic [0:31] dmem_wdata,
    output logic [0:3]  dmem_be,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic [0:31] dmem_rdata,
    input  logic        dmem_ack,
    output logic        reg_lock,
    output logic [0:4]  write_reg_mem,
    output logic [0:31] write_val_mem,
    output logic        reg_write_mem,
    output logic [0:9]  ctrl_wb,
    output logic [0:4]  write_reg_wb,
    output logic [0:31] write_val_wb,
    output logic        bus_err,
    output logic        misalign
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t      state, nstate;
    logic [7:0]  cnt, cnt_n;

    logic        mem_op;
    logic        mis;
    logic        req;
    logic        complete;
    logic        abort;
    logic        kill;
    logic [1:0]  sz;
    logic [1:0]  off;
    logic        is_byte, is_half;
    logic [31:0] wd, rd;
    logic [31:0] wlane;
    logic [3:0]  be;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] ext;
    logic [31:0] result;
    logic [31:0] fwd_val;
    logic [0:8]  ctrl_k;

    // Lane steering for stores, extraction for loads, alignment check.
    always_comb begin
        mem_op  = ctrl[2] | ctrl[3];
        sz      = dmem_info[0:1];
        off     = alu_out[30:31];
        is_byte = (sz == 2'b00);
        is_half = (sz == 2'b01);
        wd      = write_data;
        rd      = dmem_rdata;
        wlane   = wd;
        be      = 4'b1111;
        rbyte   = 8'h00;
        rhalf   = off[1] ? rd[15:0] : rd[31:16];
        ext     = rd;
        unique case (off)
            2'd0:    rbyte = rd[31:24];
            2'd1:    rbyte = rd[23:16];
            2'd2:    rbyte = rd[15:8];
            default: rbyte = rd[7:0];
        endcase
        unique case (1'b1)
            is_byte: begin
                be    = 4'b1000 >> off;
                wlane = {4{wd[7:0]}};
                ext   = dmem_info[2] ? {24'h0, rbyte}
                                     : {{24{rbyte[7]}}, rbyte};
            end
            is_half: begin
                be    = off[1] ? 4'b0011 : 4'b1100;
                wlane = {2{wd[15:0]}};
                ext   = dmem_info[2] ? {16'h0, rhalf}
                                     : {{16{rhalf[15]}}, rhalf};
            end
            default: begin
                be    = 4'b1111;
                wlane = wd;
                ext   = rd;
            end
        endcase
`ifdef DMEM_ALIGN_CHECK_EN
        mis = mem_op & ((is_half & off[0]) |
                        ((sz == 2'b10) & (off != 2'b00)));
`else
        mis = 1'b0;
`endif
    end

    // Access FSM: issue, wait for ack, or give up after ACK_TIMEOUT waits.
    always_comb begin
        nstate   = state;
        cnt_n    = cnt;
        req      = 1'b0;
        complete = 1'b0;
        abort    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (mem_op & ~mis) begin
                    req = 1'b1;
                    if (dmem_ack) begin
                        complete = 1'b1;
                    end else begin
                        nstate = S_WAIT;
                        cnt_n  = 8'd0;
                    end
                end
            end
            default: begin
                req = 1'b1;
                if (dmem_ack) begin
                    complete = 1'b1;
                    nstate   = S_IDLE;
                    cnt_n    = 8'd0;
                end else if (cnt == 8'(ACK_TIMEOUT - 1)) begin
                    abort  = 1'b1;
                    nstate = S_IDLE;
                    cnt_n  = 8'd0;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
        endcase
    end

    // Forwarding value, stall and port drive.
    always_comb begin
        kill     = abort | mis;
        reg_lock = mem_op & ~mis & ~complete & ~abort;
        result   = ((alu_ctrl == 6'h0e) || (alu_ctrl == 6'h16))
                   ? mult_out : alu_out;
        fwd_val  = ctrl[2] ? (kill ? 32'h0 : ext) : result;
        ctrl_k    = ctrl;
        ctrl_k[4] = ctrl[4] & ~kill;
        write_val_mem = fwd_val;
        write_reg_mem = write_reg;
        reg_write_mem = ctrl[4] & ~reg_lock & ~kill;
        dmem_addr     = {alu_out[0:29], 2'b00};
        dmem_be       = be;
        dmem_wdata    = wlane;
        dmem_req      = req & ~rst;
        dmem_we       = req & ctrl[3] & ~rst;
    end

    // FSM state, timeout counter and error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= 8'd0;
            bus_err  <= 1'b0;
            misalign <= 1'b0;
        end else begin
            state    <= nstate;
            cnt      <= cnt_n;
            bus_err  <= abort;
            misalign <= mis;
        end
    end

    // MEM/WB register; a stalled cycle inserts a bubble. Bit 9 is reserved.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_wb      <= '0;
            write_reg_wb <= '0;
            write_val_wb <= '0;
        end else if (reg_lock) begin
            ctrl_wb      <= '0;
            write_reg_wb <= '0;
            write_val_wb <= '0;
        end else begin
            ctrl_wb      <= {ctrl_k, 1'b0};
            write_reg_wb <= write_reg;
            write_val_wb <= fwd_val;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: vector table plus scoreboard of MEM/WB results,
// with hand sequences for reset mid-wait and stray acks.
module tb_mem_access;

    localparam logic [8:0] MR = 9'h040;
    localparam logic [8:0] MW = 9'h020;
    localparam logic [8:0] RW = 9'h010;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [0:8]  ctrl = '0;
    logic [0:5]  alu_ctrl = '0;
    logic [0:31] alu_out = '0;
    logic [0:31] mult_out = '0;
    logic [0:31] write_data = '0;
    logic [0:2]  dmem_info = '0;
    logic [0:4]  write_reg = '0;
    logic [0:31] dmem_addr;
    logic [0:31] dmem_wdata;
    logic [0:3]  dmem_be;
    logic        dmem_req;
    logic        dmem_we;
    logic [0:31] dmem_rdata = '0;
    logic        dmem_ack = 1'b0;
    logic        reg_lock;
    logic [0:4]  write_reg_mem;
    logic [0:31] write_val_mem;
    logic        reg_write_mem;
    logic [0:9]  ctrl_wb;
    logic [0:4]  write_reg_wb;
    logic [0:31] write_val_wb;
    logic        bus_err;
    logic        misalign;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_access #(.ACK_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .ctrl(ctrl), .alu_ctrl(alu_ctrl),
        .alu_out(alu_out), .mult_out(mult_out),
        .write_data(write_data), .dmem_info(dmem_info),
        .write_reg(write_reg), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .reg_lock(reg_lock), .write_reg_mem(write_reg_mem),
        .write_val_mem(write_val_mem),
        .reg_write_mem(reg_write_mem), .ctrl_wb(ctrl_wb),
        .write_reg_wb(write_reg_wb), .write_val_wb(write_val_wb),
        .bus_err(bus_err), .misalign(misalign)
    );

    typedef struct {
        string       name;
        logic [8:0]  ctrl;
        logic [5:0]  aluc;
        logic [31:0] alu;
        logic [31:0] mul;
        logic [31:0] wdat;
        logic [2:0]  info;
        logic [4:0]  wreg;
        logic [31:0] rdata;
        int          waits;
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] lane;
        int          lock;
        logic [31:0] val;
        logic        kill;
        logic        berr;
        logic        mis;
    } vec_t;

    typedef struct {
        logic [9:0]  cw;
        logic [4:0]  wreg;
        logic [31:0] val;
    } wb_t;

    vec_t vt[$];
    wb_t  sb[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input string nm, input logic [8:0] c, input logic [5:0] ac,
        input logic [31:0] a, input logic [31:0] m,
        input logic [31:0] w, input logic [2:0] inf,
        input logic [4:0] r, input logic [31:0] rdv, input int wt,
        input logic rq, input logic we, input logic [31:0] ad,
        input logic [3:0] b, input logic [31:0] ln, input int lk,
        input logic [31:0] v, input logic k, input logic be_,
        input logic ms);
        vec_t t;
        t.name = nm; t.ctrl = c; t.aluc = ac; t.alu = a; t.mul = m;
        t.wdat = w; t.info = inf; t.wreg = r; t.rdata = rdv;
        t.waits = wt; t.req = rq; t.we = we; t.addr = ad; t.be = b;
        t.lane = ln; t.lock = lk; t.val = v; t.kill = k;
        t.berr = be_; t.mis = ms;
        return t;
    endfunction

    task automatic run_vec(input vec_t v);
        int   lk;
        bit   done;
        wb_t  e;
        logic [8:0] cm;
        cm = v.ctrl & ~(v.kill ? RW : 9'h0);
        e.cw = {cm, 1'b0};
        e.wreg = v.wreg;
        e.val = v.val;
        sb.push_back(e);
        ctrl = v.ctrl; alu_ctrl = v.aluc; alu_out = v.alu;
        mult_out = v.mul; write_data = v.wdat; dmem_info = v.info;
        write_reg = v.wreg; dmem_rdata = v.rdata;
        dmem_ack = (v.waits == 0);
        lk = 0;
        done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            chk({v.name, ".req"}, 32'(dmem_req), 32'(v.req));
            if (c == 0 && v.req) begin
                chk({v.name, ".addr"}, dmem_addr, v.addr);
                chk({v.name, ".be"}, 32'(dmem_be), 32'(v.be));
                chk({v.name, ".we"}, 32'(dmem_we), 32'(v.we));
                if (v.we) chk({v.name, ".wdata"}, dmem_wdata, v.lane);
            end
            if (reg_lock) begin
                lk++;
                @(posedge clk);
                #1;
                dmem_ack = (v.waits == c + 1);
            end else begin
                done = 1;
            end
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s.stall_bound: lock never released", v.name);
        end
        chk({v.name, ".lock_cycles"}, 32'(lk), 32'(v.lock));
        chk({v.name, ".fwd_val"}, write_val_mem, v.val);
        chk({v.name, ".fwd_we"}, 32'(reg_write_mem),
            32'(((v.ctrl & RW) != 0) && !v.kill));
        chk({v.name, ".fwd_tag"}, 32'(write_reg_mem), 32'(v.wreg));
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s.scoreboard: queue empty", v.name);
        end else begin
            e = sb.pop_front();
            chk({v.name, ".ctrl_wb"}, 32'(ctrl_wb), 32'(e.cw));
            chk({v.name, ".reg_wb"}, 32'(write_reg_wb), 32'(e.wreg));
            chk({v.name, ".val_wb"}, write_val_wb, e.val);
        end
        chk({v.name, ".bus_err"}, 32'(bus_err), 32'(v.berr));
        chk({v.name, ".misalign"}, 32'(misalign), 32'(v.mis));
        ctrl = '0;
        alu_ctrl = '0;
        dmem_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt.push_back(mk("sb", MW, 6'h00, 32'h1003, 0, 32'hA5, 3'b000,
            5'd0, 0, 0, 1, 1, 32'h1000, 4'b0001, 32'hA5A5A5A5, 0,
            32'h1003, 0, 0, 0));
        vt.push_back(mk("lh", MR | RW, 6'h00, 32'h2002, 0, 0, 3'b010,
            5'd5, 32'h1234F00D, 3, 1, 0, 32'h2000, 4'b0011, 0, 3,
            32'hFFFFF00D, 0, 0, 0));
        vt.push_back(mk("lhu", MR | RW, 6'h00, 32'h2002, 0, 0, 3'b011,
            5'd6, 32'h1234F00D, 3, 1, 0, 32'h2000, 4'b0011, 0, 3,
            32'h0000F00D, 0, 0, 0));
        vt.push_back(mk("mul", RW, 6'h0e, 32'h55, 32'h6, 0, 3'b000,
            5'd7, 0, 0, 0, 0, 0, 0, 0, 0, 32'h6, 0, 0, 0));
        vt.push_back(mk("mulu", RW | 9'h001, 6'h16, 32'h55,
            32'hFFFF0000, 0, 3'b000, 5'd8, 0, 0, 0, 0, 0, 0, 0, 0,
            32'hFFFF0000, 0, 0, 0));
        vt.push_back(mk("alu", RW | 9'h100, 6'h00, 32'hDEADBEEF, 32'h7,
            0, 3'b000, 5'd9, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF,
            0, 0, 0));
        vt.push_back(mk("lb", MR | RW, 6'h00, 32'h4001, 0, 0, 3'b000,
            5'd10, 32'h1280FFFF, 0, 1, 0, 32'h4000, 4'b0100, 0, 0,
            32'hFFFFFF80, 0, 0, 0));
        vt.push_back(mk("lbu", MR | RW, 6'h00, 32'h4002, 0, 0, 3'b001,
            5'd16, 32'h1280FF7F, 0, 1, 0, 32'h4000, 4'b0010, 0, 0,
            32'h000000FF, 0, 0, 0));
        vt.push_back(mk("lw", MR | RW, 6'h00, 32'h5000, 0, 0, 3'b100,
            5'd11, 32'hCAFEBABE, 1, 1, 0, 32'h5000, 4'b1111, 0, 1,
            32'hCAFEBABE, 0, 0, 0));
        vt.push_back(mk("sw", MW, 6'h00, 32'h6004, 0, 32'h12345678,
            3'b100, 5'd0, 0, 2, 1, 1, 32'h6004, 4'b1111, 32'h12345678,
            2, 32'h6004, 0, 0, 0));
        vt.push_back(mk("sh", MW, 6'h00, 32'h7002, 0, 32'h0000BEEF,
            3'b010, 5'd0, 0, 0, 1, 1, 32'h7000, 4'b0011, 32'hBEEFBEEF,
            0, 32'h7002, 0, 0, 0));
        vt.push_back(mk("tmo", MR | RW, 6'h00, 32'h8000, 0, 0, 3'b100,
            5'd12, 32'h99999999, 99, 1, 0, 32'h8000, 4'b1111, 0, 4,
            32'h0, 1, 1, 0));
        vt.push_back(mk("ackto", MR | RW, 6'h00, 32'h8010, 0, 0, 3'b100,
            5'd13, 32'h0BADF00D, 4, 1, 0, 32'h8010, 4'b1111, 0, 4,
            32'h0BADF00D, 0, 0, 0));
`ifdef DMEM_ALIGN_CHECK_EN
        vt.push_back(mk("lwmis", MR | RW, 6'h00, 32'h3001, 0, 0, 3'b100,
            5'd14, 32'h11223344, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 1));
`else
        vt.push_back(mk("lwmis", MR | RW, 6'h00, 32'h3001, 0, 0, 3'b100,
            5'd14, 32'h11223344, 0, 1, 0, 32'h3000, 4'b1111, 0, 0,
            32'h11223344, 0, 0, 0));
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.ctrl_wb", 32'(ctrl_wb), 0);
        chk("rst.reg_wb", 32'(write_reg_wb), 0);
        chk("rst.val_wb", write_val_wb, 0);
        chk("rst.bus_err", 32'(bus_err), 0);
        chk("rst.misalign", 32'(misalign), 0);
        ctrl = MR | RW;
        #1;
        chk("rst.req_gated", 32'(dmem_req), 0);
        ctrl = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (vt[i]) run_vec(vt[i]);

        dmem_ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("stray_ack.req", 32'(dmem_req), 0);
            chk("stray_ack.lock", 32'(reg_lock), 0);
            @(posedge clk);
            #1;
            chk("stray_ack.bus_err", 32'(bus_err), 0);
        end
        dmem_ack = 1'b0;

        ctrl = MR | RW; alu_out = 32'h9000; dmem_info = 3'b100;
        write_reg = 5'd15; dmem_rdata = 32'h77777777;
        @(negedge clk);
        chk("rstw.lock_idle", 32'(reg_lock), 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rstw.req_wait", 32'(dmem_req), 1);
        #1;
        rst = 1'b1;
        #1;
        chk("rstw.req_drop", 32'(dmem_req), 0);
        chk("rstw.ctrl_wb", 32'(ctrl_wb), 0);
        chk("rstw.val_wb", write_val_wb, 0);
        ctrl = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        dmem_ack = 1'b1;
        @(negedge clk);
        chk("rstw.lock_after", 32'(reg_lock), 0);
        chk("rstw.req_after", 32'(dmem_req), 0);
        @(posedge clk);
        #1;
        chk("rstw.no_write", 32'(ctrl_wb), 0);
        chk("rstw.bus_err", 32'(bus_err), 0);
        dmem_ack = 1'b0;

        run_vec(mk("lw_post", MR | RW, 6'h00, 32'hA008, 0, 0, 3'b100,
            5'd20, 32'h5A5AA5A5, 2, 1, 0, 32'hA008, 4'b1111, 0, 2,
            32'h5A5AA5A5, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
